// File: rtl/spi_arbiter_if.sv
// ----------------------------------------------------------------------------
// spi_arbiter_if
// Requester-side bundle of the SPI arbiter.
//   req       requester -> arbiter  level request, one bit per requester
//   req_data  requester -> arbiter  byte per requester, [8i+7:8i] for requester i
//   req_cpol  requester -> arbiter  clock polarity per requester
//   req_cpha  requester -> arbiter  clock phase per requester
//   gnt       arbiter -> requester  one-hot grant
//   done      arbiter -> requester  one-cycle completion pulse
//   err       arbiter -> requester  one-cycle timeout pulse
//   busy      arbiter -> requester  arbiter is not idle
// master modport: requester side; slave modport: arbiter side.
// ----------------------------------------------------------------------------
interface spi_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_cpol;
    logic [N-1:0]   req_cpha;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [N-1:0]   err;
    logic           busy;

    modport master (
        output req, req_data, req_cpol, req_cpha,
        input  gnt, done, err, busy
    );

    modport slave (
        input  req, req_data, req_cpol, req_cpha,
        output gnt, done, err, busy
    );
endinterface

// File: rtl/spi_arbiter.sv
// ----------------------------------------------------------------------------
// spi_arbiter
// Round-robin arbiter/sequencer sharing one spigen SPI master between N
// requesters. The winner's byte and mode are latched, spigen is started with
// a one-cycle pulse, the frame is tracked through spigen's cs, a guard gap is
// enforced, and a done (or err on start timeout) pulse goes to the winner.
// Ports:
//   clk        system clock, shared with spigen
//   rst_n      asynchronous active-low reset
//   bus        requester bundle (slave modport): req/req_data/req_cpol/
//              req_cpha in, gnt/done/err/busy out
//   spi_start  one-cycle start pulse to spigen
//   spi_p_dat  latched byte to spigen
//   spi_cpol   latched clock polarity to spigen
//   spi_cpha   latched clock phase to spigen
//   spi_cs     chip select from spigen (active low)
// ----------------------------------------------------------------------------
module spi_arbiter #(
    parameter int N          = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TMO_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_arbiter_if.slave bus,
    output logic         spi_start,
    output logic [7:0]   spi_p_dat,
    output logic         spi_cpol,
    output logic         spi_cpha,
    input  logic         spi_cs
);

    localparam int PW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_GAP,
        S_DONE
    } state_t;

    state_t         state, state_nx;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   done_q, done_d;
    logic [N-1:0]   err_q, err_d;
    logic           start_d;
    logic [7:0]     dat_d;
    logic           cpol_d, cpha_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           failed_q, failed_d;   // current frame ended by timeout
    logic           cs_ok_q, cs_ok_d;     // spigen seen idle (cs high) since reset
    logic [PW-1:0]  win_idx;
    logic           win_any;

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.busy = (state != S_IDLE);

    // Round-robin pick: first set req bit at or after ptr, with wrap-around.
    always_comb begin
        int idx;
        idx     = 0;
        win_any = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!win_any && bus.req[idx]) begin
                win_any = 1'b1;
                win_idx = PW'(idx);
            end
        end
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            spi_start <= 1'b0;
            spi_p_dat <= '0;
            spi_cpol  <= 1'b0;
            spi_cpha  <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            failed_q  <= 1'b0;
            cs_ok_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            spi_start <= start_d;
            spi_p_dat <= dat_d;
            spi_cpol  <= cpol_d;
            spi_cpha  <= cpha_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            failed_q  <= failed_d;
            cs_ok_q   <= cs_ok_d;
        end
    end

    // Next-state logic.
    // NOTE: each combinational block assigns a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (|bus.req && cs_ok_q) state_nx = S_ARB;
            S_ARB:       state_nx = win_any ? S_LAUNCH : S_IDLE;
            S_LAUNCH:    state_nx = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!spi_cs)                             state_nx = S_WAIT_HIGH;
                else if (cnt_q == 8'(TMO_CYCLES - 1))    state_nx = S_GAP;
            end
            S_WAIT_HIGH: if (spi_cs) state_nx = S_GAP;
            S_GAP: begin
                if (cnt_q == 8'(GAP_CYCLES - 1)) state_nx = failed_q ? S_IDLE : S_DONE;
            end
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = '0;
        start_d  = 1'b0;
        dat_d    = spi_p_dat;
        cpol_d   = spi_cpol;
        cpha_d   = spi_cpha;
        ptr_d    = ptr_q;
        failed_d = failed_q;
        cs_ok_d  = cs_ok_q | spi_cs;
        // One counter serves both the start timeout and the guard gap: it
        // restarts from zero on every state change.
        cnt_d    = (state_nx == state) ? cnt_q + 8'd1 : 8'd0;

        case (state)
            S_ARB: begin
                if (win_any) begin
                    gnt_d    = N'(1) << win_idx;
                    dat_d    = bus.req_data[8*int'(win_idx) +: 8];
                    cpol_d   = bus.req_cpol[win_idx];
                    cpha_d   = bus.req_cpha[win_idx];
                    ptr_d    = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
                    failed_d = 1'b0;
                end else begin
                    gnt_d = '0;
                end
            end
            S_LAUNCH: start_d = 1'b1;
            S_WAIT_LOW: begin
                if (state_nx == S_GAP) begin
                    err_d    = gnt_q;
                    gnt_d    = '0;
                    failed_d = 1'b1;
                end
            end
            S_GAP:  if (state_nx == S_DONE) done_d = gnt_q;
            S_DONE: gnt_d = '0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spi_arbiter
// Directed bench for spi_arbiter. The bench plays spigen's cs by hand and
// checks grant order, latency, latched data/mode, done/err timing and reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_spi_arbiter;

    localparam int N   = 4;
    localparam int GAP = 4;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_start;
    logic [7:0] spi_p_dat;
    logic       spi_cpol;
    logic       spi_cpha;
    logic       spi_cs;

    int n_checks = 0;
    int n_pass   = 0;

    spi_arbiter_if #(.N(N)) bus ();

    spi_arbiter #(
        .N          (N),
        .GAP_CYCLES (GAP),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .spi_start (spi_start),
        .spi_p_dat (spi_p_dat),
        .spi_cpol  (spi_cpol),
        .spi_cpha  (spi_cpha),
        .spi_cs    (spi_cs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Wait (bounded) for any grant; lat counts falling edges waited.
    task automatic wait_gnt(output int lat);
        lat = 0;
        while (bus.gnt == '0 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // One complete normal frame for expected winner w.
    task automatic frame(input int w, input logic [7:0] dat, input logic [1:0] mode,
                         input bit scramble, output int lat);
        logic [3:0] one;
        int bad;
        one = 4'b0001 << w;
        wait_gnt(lat);
        check($sformatf("gnt_w%0d", w), bus.gnt, one);
        step();
        check("start_high", spi_start, 1'b1);
        check("p_dat", spi_p_dat, dat);
        check("mode", {spi_cpol, spi_cpha}, mode);
        step();
        check("start_one_cycle", spi_start, 1'b0);
        spi_cs = 1'b0;
        if (scramble) begin
            bus.req_data = ~bus.req_data;
            bus.req_cpol = ~bus.req_cpol;
            bus.req_cpha = ~bus.req_cpha;
        end
        repeat (4) step();
        spi_cs = 1'b1;
        bad = 0;
        for (int k = 0; k < GAP; k++) begin
            step();
            if (bus.done != '0 || bus.err != '0 || bus.gnt != one ||
                spi_p_dat != dat || {spi_cpol, spi_cpha} != mode || !bus.busy) bad++;
        end
        check("gap_hold", bad, 0);
        step();
        check("done", bus.done, one);
        check("done_no_err", bus.err, '0);
        check("done_dat_hold", {spi_p_dat, spi_cpol, spi_cpha}, {dat, mode});
        step();
        check("done_pulse", bus.done, '0);
        check("gnt_clear", bus.gnt, '0);
    endtask

    initial begin
        int lat;
        int bad;

        rst_n        = 1'b1;
        spi_cs       = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_cpol = '0;
        bus.req_cpha = '0;
        #2 rst_n = 1'b0;
        repeat (2) step();
        check("reset_outs", {bus.gnt, bus.done, bus.err, bus.busy, spi_start, spi_cpol, spi_cpha},
              '0);
        check("reset_p_dat", spi_p_dat, 8'h00);
        rst_n = 1'b1;
        repeat (2) step();

        // Single request with latency check: gnt two edges after req, start at three.
        bus.req_data[7:0] = 8'hA5;
        bus.req           = 4'b0001;
        frame(0, 8'hA5, 2'b00, 1'b0, lat);
        check("gnt_latency", lat, 2);
        bus.req = '0;
        step();

        // Wrap-around: serve 3 (ptr -> 0), then 1001 must go to 0 first.
        bus.req_data[31:24] = 8'h81;
        bus.req_cpol        = 4'b1000;
        bus.req             = 4'b1000;
        frame(3, 8'h81, 2'b10, 1'b0, lat);
        bus.req = 4'b1001;
        frame(0, 8'hA5, 2'b00, 1'b0, lat);
        bus.req = 4'b1000;
        frame(3, 8'h81, 2'b10, 1'b0, lat);
        bus.req = '0;
        step();

        // Contention: all four held, order 0,1,2,3,0.
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_cpol = 4'b0101;
        bus.req_cpha = 4'b0011;
        bus.req      = 4'b1111;
        frame(0, 8'h11, 2'b11, 1'b0, lat);
        frame(1, 8'h22, 2'b01, 1'b0, lat);
        frame(2, 8'h33, 2'b10, 1'b0, lat);
        frame(3, 8'h44, 2'b00, 1'b0, lat);
        frame(0, 8'h11, 2'b11, 1'b0, lat);
        bus.req = '0;
        step();

        // Mode/data stability: requester 2 (ptr=1), inputs scrambled mid-frame.
        bus.req_data[23:16] = 8'h3C;
        bus.req_cpol        = 4'b0100;
        bus.req_cpha        = 4'b0100;
        bus.req             = 4'b0100;
        frame(2, 8'h3C, 2'b11, 1'b1, lat);
        bus.req = '0;
        step();

        // Timeout: cs stays high; requester 1 wins (ptr=3 scans 3,0,1).
        bus.req_data = 32'h0000_C35A;
        bus.req_cpol = '0;
        bus.req_cpha = '0;
        bus.req      = 4'b0010;
        wait_gnt(lat);
        check("tmo_gnt", bus.gnt, 4'b0010);
        step();
        check("tmo_start", spi_start, 1'b1);
        bad = 0;
        repeat (TMO - 1) begin
            step();
            if (bus.err != '0) bad++;
        end
        check("tmo_not_early", bad, 0);
        step();
        check("tmo_err", bus.err, 4'b0010);
        check("tmo_no_done", bus.done, '0);
        check("tmo_gnt_clear", bus.gnt, '0);
        bus.req = '0;
        step();
        check("tmo_err_pulse", bus.err, '0);
        bad = 0;
        repeat (GAP + 2) begin
            step();
            if (bus.done != '0 || spi_start) bad++;
        end
        check("tmo_quiet", bad, 0);
        check("tmo_idle", bus.busy, 1'b0);
        // Next request is served normally (ptr=2 scans 2,3,0).
        bus.req = 4'b0001;
        frame(0, 8'h5A, 2'b00, 1'b0, lat);

        // Async reset during WAIT_HIGH, with spigen's cs still low afterwards.
        wait_gnt(lat);
        check("rst_pre_gnt", bus.gnt, 4'b0001);
        step();
        step();
        spi_cs = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {bus.gnt, bus.done, bus.err, bus.busy, spi_start, spi_cpol, spi_cpha},
              '0);
        check("rst_mid_p_dat", spi_p_dat, 8'h00);
        step();
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            step();
            if (spi_start || bus.busy || bus.gnt != '0) bad++;
        end
        check("rst_wait_cs", bad, 0);
        spi_cs = 1'b1;
        frame(0, 8'h5A, 2'b00, 1'b0, lat);
        bus.req = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one `spigen` SPI master between N requesters.
- Latches the winner's byte and mode (cpol/cpha), then issues a single-cycle start to `spigen`.
- Tracks the transaction through `spigen`'s cs output, enforces an inter-frame guard gap, and returns a per-requester done or error pulse.
- Sits between the system-side requesters and the `spigen` instance.

Parameters:
- N, 4, number of requesters (2..8)
- GAP_CYCLES, 4, guard clocks after cs rises before the next start (1..15)
- TMO_CYCLES, 8, max clocks to wait for cs to fall after start before flagging an error (2..255)

Ports:
- clk  in  1  system clock, shared with `spigen`
- rst_n  in  1  asynchronous active-low reset
- req  in  N  level request per requester; held until that requester's done/err pulse
- req_data  in  8N  byte per requester; requester i uses bits [8i+7:8i]
- req_cpol  in  N  clock polarity per requester
- req_cpha  in  N  clock phase per requester
- gnt  out  N  one-hot grant, held from ARB until DONE
- done  out  N  one-cycle completion pulse to the granted requester
- err  out  N  one-cycle timeout pulse to the granted requester
- busy  out  1  high in every state except IDLE
- spi_start  out  1  one-cycle start pulse to `spigen`
- spi_p_dat  out  8  latched byte to `spigen`
- spi_cpol  out  1  latched cpol to `spigen`
- spi_cpha  out  1  latched cpha to `spigen`
- spi_cs  in  1  cs from `spigen` (active low)

Behaviour:
- Reset values (asynchronous, all outputs): gnt=0, done=0, err=0, busy=0, spi_start=0, spi_p_dat=0, spi_cpol=0, spi_cpha=0. Round-robin pointer ptr=0. State=IDLE.
- FSM: IDLE -> ARB -> LAUNCH -> WAIT_LOW -> WAIT_HIGH -> GAP -> DONE -> IDLE.
- IDLE: if req != 0, go to ARB next cycle.
- ARB: select the first set req bit scanning from ptr upward, with wrap-around.
  - Set gnt one-hot for the winner.
  - Latch spi_p_dat, spi_cpol and spi_cpha from the winner.
  - Set ptr = (winner + 1) mod N.
  - If req has fallen to 0 by this cycle, return to IDLE with gnt=0.
- LAUNCH: spi_start=1 for exactly one cycle. Clear the timeout counter.
- WAIT_LOW: wait for spi_cs=0.
  - Count clocks; if the count reaches TMO_CYCLES with cs still high, pulse err[winner], clear gnt, go to GAP.
- WAIT_HIGH: wait for spi_cs=1. No timeout.
- GAP: count GAP_CYCLES clocks.
  - spi_p_dat, spi_cpol and spi_cpha stay stable through GAP, so trailing sclk edges are never corrupted.
  - Exit to DONE on a normal completion, or to IDLE after an error.
- DONE: pulse done[winner] for one cycle, clear gnt, go to IDLE.
- Minimum request-to-request spacing: no new ARB before the one IDLE cycle that follows DONE.
- Latency: req rising in IDLE gives gnt at cycle +2 and spi_start at cycle +3.
- Data and mode are sampled only in ARB. Changes to req_data, req_cpol or req_cpha during a transaction are ignored.
- If the winner drops req mid-transaction, the frame still completes and done is still pulsed.
- A newly arriving request never preempts the current one; it is considered at the next ARB.
- Simultaneous requests: strict round-robin from ptr. For example, with ptr=0 and req=4'b1010, requester 1 wins and ptr becomes 2.
- Reset mid-operation: all outputs return to reset values immediately. `spigen` has no reset, so after reset deassertion the block waits in IDLE for spi_cs=1 before it may leave IDLE.
- gnt, done and err are always one-hot or zero.

Test Plan:
- Single request: req=4'b0001, data0=8'hA5, cpol=0, cpha=0 -> gnt=0001 two cycles later; spi_start one cycle; spi_p_dat=A5 and mode 00 held until done; done=0001 once, GAP_CYCLES+1 clocks after cs rises.
- Contention: req=4'b1111 held -> grant order 0,1,2,3,0; exactly one done per frame, each in grant order; never two gnt bits set.
- Wrap-around: first serve requester 3, then assert req=4'b1001 -> requester 0 wins (ptr=0) before requester 3.
- Timeout: spi_cs tied high -> err[winner] pulses TMO_CYCLES clocks after spi_start, no done, block returns to IDLE and serves the next request.
- Mode/data stability: requester 2 with cpol=1, cpha=1, data=8'h3C; toggle req_data and cfg mid-frame -> spi_p_dat=3C and mode 11 unchanged through GAP.
- Async reset mid-WAIT_HIGH: assert rst_n=0 -> all outputs 0 immediately; after release, no new start until spi_cs=1.
